// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and the writeback request record used by the RF write-port scheduler.
package rf_wb_sched_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wd;
  } wb_req_t;

  // One-hot of a register index; x0 maps to all-zero because it is never tracked.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] v;
    v    = '0;
    v[r] = (r != '0);
    return v;
  endfunction

endpackage

// File: rtl/rf_wb_skid.sv
// One-entry skid buffer for long-latency writebacks, with a wait counter that
// raises starve once a buffered entry has been blocked by fast writes too long.
module rf_wb_skid
  import rf_wb_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  wb_req_t          in_req,
  output logic             in_ready,
  input  logic             port_free,
  output logic             drain,
  output logic [REG_W-1:0] buf_rd,
  output logic [XLEN-1:0]  buf_wd,
  output logic             starve
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic             buf_valid_reg;
  logic [REG_W-1:0] buf_rd_reg;
  logic [XLEN-1:0]  buf_wd_reg;
  logic [SW-1:0]    starve_cnt_reg;
  logic             accept;

  // The entry leaves whenever the fast path leaves the port idle.
  assign drain    = buf_valid_reg && port_free && !rst;
  assign in_ready = !rst && (!buf_valid_reg || drain);
  assign accept   = in_req.valid && in_ready;
  assign buf_rd   = buf_rd_reg;
  assign buf_wd   = buf_wd_reg;
  assign starve   = (starve_cnt_reg >= SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_reg  <= 1'b0;
      buf_rd_reg     <= '0;
      buf_wd_reg     <= '0;
      starve_cnt_reg <= '0;
    end else begin
      if (accept) begin
        buf_valid_reg <= 1'b1;
        buf_rd_reg    <= in_req.rd;
        buf_wd_reg    <= in_req.wd;
      end else if (drain) begin
        buf_valid_reg <= 1'b0;
      end

      // Saturates at the limit so starve stays asserted until the drain.
      if (!buf_valid_reg || drain) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != SW'(STARVE_LIMIT)) begin
        starve_cnt_reg <= starve_cnt_reg + SW'(1);
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// RF write-port scheduler: fast writeback has priority, long writebacks drain from a skid
// buffer, and a busy scoreboard stalls issue. Define RF_SB_BYPASS_EN to unmask commits early.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_rs1,
  input  logic [REG_W-1:0] iss_rs2,
  input  logic [REG_W-1:0] iss_rd,
  input  logic             iss_long,
  output logic             iss_stall,
  input  logic             fwb_valid,
  input  logic [REG_W-1:0] fwb_rd,
  input  logic [XLEN-1:0]  fwb_wd,
  input  logic             lwb_valid,
  output logic             lwb_ready,
  input  logic [REG_W-1:0] lwb_rd,
  input  logic [XLEN-1:0]  lwb_wd,
  output logic             rf_wr,
  output logic [REG_W-1:0] rf_a3,
  output logic [XLEN-1:0]  rf_wd,
  output logic [NREGS-1:0] busy_vec
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic             fwb_take;
  logic             drain;
  logic             starve;
  logic [REG_W-1:0] buf_rd;
  logic [XLEN-1:0]  buf_wd;
  wb_req_t          lwb_req;

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] busy_chk;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             hazard;
  logic             iss_accept;
  logic             iss_long_accept;

  // A fast write to x0 is a no-op and leaves the port to the buffer.
  assign fwb_take = fwb_valid && (fwb_rd != '0);
  assign lwb_req  = '{valid: lwb_valid, rd: lwb_rd, wd: lwb_wd};

  rf_wb_skid #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_req   (lwb_req),
    .in_ready (lwb_ready),
    .port_free(!fwb_take),
    .drain    (drain),
    .buf_rd   (buf_rd),
    .buf_wd   (buf_wd),
    .starve   (starve)
  );

  always_comb begin
    rf_wr = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (!rst) begin
      if (fwb_take) begin
        rf_wr = 1'b1;
        rf_a3 = fwb_rd;
        rf_wd = fwb_wd;
      end else if (drain && (buf_rd != '0)) begin
        rf_wr = 1'b1;
        rf_a3 = buf_rd;
        rf_wd = buf_wd;
      end
    end
  end

`ifdef RF_SB_BYPASS_EN
  // The committing value is on rf_wd this cycle, so its consumer may issue now.
  assign busy_chk = drain ? (busy_reg & ~reg_onehot(buf_rd)) : busy_reg;
`else
  assign busy_chk = busy_reg;
`endif

  assign hazard = busy_chk[iss_rs1] | busy_chk[iss_rs2] | busy_chk[iss_rd]
                | (iss_long && (cnt_reg == CW'(MAX_OUTSTANDING)))
                | starve;
  assign iss_stall       = rst || (iss_valid && hazard);
  assign iss_accept      = iss_valid && !iss_stall;
  assign iss_long_accept = iss_accept && iss_long;

  // Per-register update; a same-cycle set beats the clear since the new op is younger.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_bit
        logic set_b;
        logic clr_b;
        assign set_b         = iss_long_accept && (iss_rd == REG_W'(gi));
        assign clr_b         = drain && (buf_rd == REG_W'(gi));
        assign busy_next[gi] = set_b | (busy_reg[gi] & ~clr_b);
      end
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (iss_long_accept && !drain) begin
      cnt_next = cnt_reg + CW'(1);
    end else if (drain && !iss_long_accept && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy_vec = busy_reg;

  a_no_drain_at_zero: assert property (@(posedge clk) disable iff (rst)
    !(drain && (cnt_reg == '0)));

  a_fwb_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(fwb_take && busy_reg[fwb_rd]));

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: per-cycle vector table plus starvation and reset
// sequences; long writes are checked through a queue of expected RF writes.
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

`ifdef RF_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid;
  logic [REG_W-1:0] iss_rs1, iss_rs2, iss_rd;
  logic             iss_long;
  logic             iss_stall;
  logic             fwb_valid;
  logic [REG_W-1:0] fwb_rd;
  logic [XLEN-1:0]  fwb_wd;
  logic             lwb_valid;
  logic             lwb_ready;
  logic [REG_W-1:0] lwb_rd;
  logic [XLEN-1:0]  lwb_wd;
  logic             rf_wr;
  logic [REG_W-1:0] rf_a3;
  logic [XLEN-1:0]  rf_wd;
  logic [NREGS-1:0] busy_vec;

  always #5 clk = ~clk;

  rf_wb_sched #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .fwb_valid(fwb_valid), .fwb_rd(fwb_rd), .fwb_wd(fwb_wd),
    .lwb_valid(lwb_valid), .lwb_ready(lwb_ready), .lwb_rd(lwb_rd), .lwb_wd(lwb_wd),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd), .busy_vec(busy_vec)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        lng;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fwd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        es;
    logic        er;
    logic        ew;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  vec_t tv[$];
  wr_t  lq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int r, input int iv, input int rs1, input int rs2,
                              input int rd, input int lng, input int fv, input int frd,
                              input int fwd, input int lv, input int lrd, input int lwd,
                              input int es, input int er, input int ew, input int eb);
    vec_t v;
    v.rst = (r != 0);   v.iv  = (iv != 0);  v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.rd  = 5'(rd);     v.lng = (lng != 0); v.fv  = (fv != 0); v.frd = 5'(frd);
    v.fwd = fwd;        v.lv  = (lv != 0);  v.lrd = 5'(lrd); v.lwd = lwd;
    v.es  = (es != 0);  v.er  = (er != 0);  v.ew  = (ew != 0); v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fast writes must appear in the cycle they are driven; long writes pop in acceptance order.
  task automatic sb_check(input string tag);
    wr_t w;
    if (rst) begin
      chk({tag, ".rst_a3"}, 32'(rf_a3), 32'h0);
      chk({tag, ".rst_wd"}, rf_wd, 32'h0);
      lq.delete();
    end else if (fwb_valid && (fwb_rd != 5'd0)) begin
      chk({tag, ".fast_a3"}, 32'(rf_a3), 32'(fwb_rd));
      chk({tag, ".fast_wd"}, rf_wd, fwb_wd);
    end else if (rf_wr) begin
      if (lq.size() == 0) begin
        chk({tag, ".unexpected_wr"}, 32'(rf_a3), 32'hFFFF_FFFF);
      end else begin
        w = lq.pop_front();
        chk({tag, ".long_a3"}, 32'(rf_a3), 32'(w.rd));
        chk({tag, ".long_wd"}, rf_wd, w.wd);
      end
    end
    if (!rst && lwb_valid && lwb_ready && (lwb_rd != 5'd0))
      lq.push_back('{rd: lwb_rd, wd: lwb_wd});
  endtask

  task automatic run_vec(input vec_t v, input string name);
    rst = v.rst; iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd;
    iss_long = v.lng; fwb_valid = v.fv; fwb_rd = v.frd; fwb_wd = v.fwd;
    lwb_valid = v.lv; lwb_rd = v.lrd; lwb_wd = v.lwd;
    #4;
    chk({name, ".stall"}, 32'(iss_stall), 32'(v.es));
    chk({name, ".ready"}, 32'(lwb_ready), 32'(v.er));
    chk({name, ".rf_wr"}, 32'(rf_wr), 32'(v.ew));
    chk({name, ".busy"}, busy_vec, v.eb);
    sb_check(name);
    @(posedge clk);
    #1;
    $display("%s: stall=%0b ready=%0b rf_wr=%0b a3=%0d wd=%08h busy=%08h", name,
             iss_stall, lwb_ready, rf_wr, rf_a3, rf_wd, busy_vec);
  endtask

  initial begin
    // RAW on a long result
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 1,0,0,5,1, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 1,5,0,6,0, 0,0,0,      0,0,0,           1,1,0, 32'h20));
    tv.push_back(mk(0, 1,5,0,6,0, 0,0,0,      1,5,32'hDEADBEEF,1,1,0, 32'h20));
    tv.push_back(mk(0, 1,5,0,6,0, 0,0,0,      0,0,0,  int'(!BYP),1,1, 32'h20));
    tv.push_back(mk(0, 1,5,0,6,0, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    // fast/long conflict
    tv.push_back(mk(0, 1,0,0,7,1, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,3,32'h11, 1,7,32'h77,      0,1,1, 32'h80));
    tv.push_back(mk(0, 0,0,0,0,0, 1,3,32'h12, 0,0,0,           0,0,1, 32'h80));
    tv.push_back(mk(0, 0,0,0,0,0, 1,3,32'h13, 0,0,0,           0,0,1, 32'h80));
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      0,0,0,           0,1,1, 32'h80));
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    // register 0 handling
    tv.push_back(mk(0, 1,0,0,0,1, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 1,0,0,9,1, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      1,0,32'h55,      0,1,0, 32'h200));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,32'hABCD,1,9,32'h99,     0,1,0, 32'h200));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,32'h1234,0,0,0,          0,1,1, 32'h200));
    tv.push_back(mk(0, 0,0,0,0,0, 0,0,0,      0,0,0,           0,1,0, 32'h0));
    // outstanding capacity
    tv.push_back(mk(0, 1,0,0,10,1, 0,0,0,     0,0,0,           0,1,0, 32'h0));
    tv.push_back(mk(0, 1,0,0,11,1, 0,0,0,     0,0,0,           0,1,0, 32'h400));
    tv.push_back(mk(0, 1,0,0,12,1, 0,0,0,     0,0,0,           0,1,0, 32'hC00));
    tv.push_back(mk(0, 1,0,0,13,1, 0,0,0,     0,0,0,           0,1,0, 32'h1C00));
    tv.push_back(mk(0, 1,0,0,14,1, 0,0,0,     0,0,0,           1,1,0, 32'h3C00));
    tv.push_back(mk(0, 1,0,0,14,1, 0,0,0,     1,10,32'hA0,     1,1,0, 32'h3C00));
    tv.push_back(mk(0, 1,0,0,14,1, 0,0,0,     1,11,32'hA1,     1,1,1, 32'h3C00));
    tv.push_back(mk(0, 1,0,0,14,1, 0,0,0,     0,0,0,           0,1,1, 32'h3800));
    tv.push_back(mk(0, 1,0,0,15,1, 0,0,0,     0,0,0,           0,1,0, 32'h7000));
    tv.push_back(mk(0, 1,0,0,16,1, 0,0,0,     1,12,32'hA2,     1,1,0, 32'hF000));
    tv.push_back(mk(0, 0,0,0,0,0,  0,0,0,     1,13,32'hA3,     0,1,1, 32'hF000));
    tv.push_back(mk(0, 0,0,0,0,0,  0,0,0,     1,14,32'hA4,     0,1,1, 32'hE000));
    tv.push_back(mk(0, 0,0,0,0,0,  0,0,0,     1,15,32'hA5,     0,1,1, 32'hC000));
    tv.push_back(mk(0, 0,0,0,0,0,  0,0,0,     0,0,0,           0,1,1, 32'h8000));
    tv.push_back(mk(0, 0,0,0,0,0,  0,0,0,     0,0,0,           0,1,0, 32'h0));

    rst = 1'b1; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_long = 1'b0;
    fwb_valid = 1'b0; fwb_rd = '0; fwb_wd = '0; lwb_valid = 1'b0; lwb_rd = '0; lwb_wd = '0;
    @(posedge clk);
    #1;
    run_vec(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 32'h0), "reset0");
    run_vec(mk(1, 1,0,0,0,0, 1,4,32'h44, 0,0,0, 1,0,0, 32'h0), "reset1");

    for (int i = 0; i < tv.size(); i++)
      run_vec(tv[i], $sformatf("row%0d", i));

    // Buffered long write blocked by a continuous fast stream.
    run_vec(mk(0, 1,0,0,20,1, 0,0,0, 0,0,0,            0,1,0, 32'h0), "starve_iss");
    run_vec(mk(0, 0,0,0,0,0,  0,0,0, 1,20,32'h2020,    0,1,0, 32'h100000), "starve_acc");
    for (int w = 0; w < 10; w++)
      run_vec(mk(0, 1,0,0,1,0, 1,3,32'h300 + w, 0,0,0, int'(w >= 8),0,1, 32'h100000),
              $sformatf("starve_w%0d", w));
    run_vec(mk(0, 1,0,0,1,0, 0,0,0, 0,0,0, 1,1,1, 32'h100000), "starve_drain");
    run_vec(mk(0, 1,0,0,1,0, 0,0,0, 0,0,0, 0,1,0, 32'h0), "starve_after");
    chk("sb.queue_empty", 32'(lq.size()), 32'h0);

    // Reset with x5 busy and its writeback sitting in the buffer.
    run_vec(mk(0, 1,0,0,5,1, 0,0,0, 0,0,0,            0,1,0, 32'h0), "rst_iss");
    run_vec(mk(0, 0,0,0,0,0, 0,0,0, 1,5,32'h1234,     0,1,0, 32'h20), "rst_acc");
    run_vec(mk(1, 1,5,0,6,0, 1,3,32'h77, 0,0,0,       1,0,0, 32'h20), "rst_mid");
    run_vec(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0,            0,1,0, 32'h0), "rst_after");
    run_vec(mk(0, 1,5,0,6,0, 0,0,0, 0,0,0,            0,1,0, 32'h0), "rst_issue");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
